// File: rtl/icache_fetch_ctrl.sv
// icache_fetch_ctrl: direct-mapped L1 instruction cache with a word-serial line refill engine.
// Define ICACHE_STATS_EN to add saturating hit_cnt / miss_cnt counter ports.
module icache_fetch_ctrl #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned LINES      = 16,
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  input  logic              flush,
  output logic [DATA_W-1:0] instr,
  output logic              stall,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
`endif
);

  localparam int unsigned OFF_W   = $clog2(LINE_WORDS);
  localparam int unsigned IDX_W   = $clog2(LINES);
  localparam int unsigned LSB_W   = OFF_W + 2;
  localparam int unsigned TAG_LSB = IDX_W + LSB_W;
  localparam int unsigned TAG_W   = ADDR_W - TAG_LSB;
  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);

  typedef enum logic {
    IDLE,
    REFILL
  } state_e;

  state_e              state_q, state_d;
  logic [OFF_W-1:0]    beat_q, beat_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [LINES-1:0]    valid_q, valid_d;
  logic                mem_req_q, mem_req_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;

  logic [DATA_W-1:0]   data_q [LINES][LINE_WORDS];
  logic [TAG_W-1:0]    tag_q  [LINES];
  logic                data_we;
  logic                tag_we;

  logic [OFF_W-1:0]    pc_off;
  logic [IDX_W-1:0]    pc_idx;
  logic [TAG_W-1:0]    pc_tag;
  logic [IDX_W-1:0]    ref_idx;
  logic [TAG_W-1:0]    ref_tag;
  logic                hit_c;
  logic                unused_pc_lsb;

  // Fetch address and latched refill base split into offset / index / tag.
  assign pc_off        = pc[LSB_W-1:2];
  assign pc_idx        = pc[TAG_LSB-1:LSB_W];
  assign pc_tag        = pc[ADDR_W-1:TAG_LSB];
  assign ref_idx       = base_q[TAG_LSB-1:LSB_W];
  assign ref_tag       = base_q[ADDR_W-1:TAG_LSB];
  assign unused_pc_lsb = ^pc[1:0];

  // Lookups only hit in IDLE; during a refill the target line is half-written.
  assign hit_c = (state_q == IDLE) && valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);
  assign stall = !hit_c;
  assign instr = hit_c ? data_q[pc_idx][pc_off] : '0;

  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    base_d  = base_q;
    valid_d = valid_q;
    data_we = 1'b0;
    tag_we  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (flush) begin
          valid_d = '0;
        end
        if (!hit_c) begin
          state_d = REFILL;
          beat_d  = '0;
          base_d  = {pc_tag, pc_idx, {LSB_W{1'b0}}};
        end
      end
      REFILL: begin
        // Flush aborts the refill and drops any beat accepted this cycle.
        if (flush) begin
          valid_d = '0;
          state_d = IDLE;
          beat_d  = '0;
        end else if (mem_ready) begin
          data_we = 1'b1;
          if (beat_q == LAST_BEAT) begin
            tag_we           = 1'b1;
            valid_d[ref_idx] = 1'b1;
            state_d          = IDLE;
            beat_d           = '0;
          end else begin
            beat_d = beat_q + OFF_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        beat_d  = '0;
      end
    endcase

    mem_req_d  = (state_d == REFILL);
    mem_addr_d = mem_req_d ? (base_d + ADDR_W'({beat_d, 2'b00})) : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      beat_q     <= '0;
      base_q     <= '0;
      valid_q    <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      base_q     <= base_d;
      valid_q    <= valid_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  // Data and tag arrays carry no reset; valid bits gate their use.
  always_ff @(posedge clk) begin
    if (data_we) begin
      data_q[ref_idx][beat_q] <= mem_rdata;
    end
    if (tag_we) begin
      tag_q[ref_idx] <= ref_tag;
    end
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  // Saturating event counters; flush clears them.
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (flush) begin
      hit_cnt_d  = '0;
      miss_cnt_d = '0;
    end else begin
      if (hit_c && (hit_cnt_q != 32'hFFFF_FFFF)) begin
        hit_cnt_d = hit_cnt_q + 32'd1;
      end
      if ((state_q == IDLE) && (state_d == REFILL) && (miss_cnt_q != 32'hFFFF_FFFF)) begin
        miss_cnt_d = miss_cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache_fetch_ctrl.sv
// Scoreboard bench for icache_fetch_ctrl: fetches are checked against a flat memory image and an
// abstract line-presence model; the memory port is served by a randomised responder.
`timescale 1ns/1ps
module tb_icache_fetch_ctrl;

  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned LINES      = 16;
  localparam int unsigned LINE_WORDS = 4;
  localparam int unsigned LINE_BYTES = LINE_WORDS * 4;
  localparam int          TIMEOUT    = 300;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [ADDR_W-1:0] pc = '0;
  logic              flush = 1'b0;
  logic [DATA_W-1:0] instr;
  logic              stall;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ready = 1'b0;
  logic [DATA_W-1:0] mem_rdata = '0;
`ifdef ICACHE_STATS_EN
  logic [31:0]       hit_cnt;
  logic [31:0]       miss_cnt;
`endif

  icache_fetch_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LINES(LINES), .LINE_WORDS(LINE_WORDS)
  ) dut (
    .clk(clk), .rst(rst), .pc(pc), .flush(flush),
    .instr(instr), .stall(stall),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
`ifdef ICACHE_STATS_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] beats_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  bit          fetch_en = 1'b0;
  int          ready_pct = 100;
  logic [31:0] hold_addr = '0;
  int          hold_cnt = 0;
  int          req_cycles = 0;

  logic [31:0] mem_ovr [logic [31:0]];
  logic [31:0] mdl_line [LINES];
  bit          mdl_valid [LINES];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tmo(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: no response within %0d cycles (t=%0t)", name, TIMEOUT, $time);
  endtask

  // Backing memory: a few fixed words, a scrambled function of the address elsewhere.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem_ovr.exists(a)) return mem_ovr[a];
    return (a * 32'h9E37_79B1) ^ 32'hC3A5_0F1E;
  endfunction

  function automatic int unsigned line_no(input logic [31:0] a);
    return a / LINE_BYTES;
  endfunction

  function automatic logic [31:0] line_base(input logic [31:0] a);
    return line_no(a) * LINE_BYTES;
  endfunction

  function automatic bit mdl_hit(input logic [31:0] a);
    int unsigned ln;
    ln = line_no(a);
    return mdl_valid[ln % LINES] && (mdl_line[ln % LINES] == ln);
  endfunction

  task automatic mdl_fill(input logic [31:0] a);
    int unsigned ln;
    ln = line_no(a);
    mdl_valid[ln % LINES] = 1'b1;
    mdl_line[ln % LINES]  = ln;
  endtask

  task automatic mdl_flush();
    for (int i = 0; i < int'(LINES); i++) mdl_valid[i] = 1'b0;
  endtask

  // Memory responder: decides mem_ready per requested beat, logs accepted beat addresses.
  initial begin
    forever begin
      @(negedge clk);
      if (mem_req && rst) begin
        req_cycles++;
        if (hold_cnt > 0 && mem_addr == hold_addr) begin
          mem_ready = 1'b0;
          hold_cnt--;
        end else begin
          mem_ready = ($urandom_range(99) < 32'(ready_pct));
        end
        mem_rdata = mem_ready ? mem_word(mem_addr) : 32'hDEAD_BEEF;
        if (mem_ready) beats_q.push_back(mem_addr);
      end else begin
        mem_ready = 1'b0;
        mem_rdata = 32'hDEAD_BEEF;
      end
    end
  end

  // Monitor: every presented instruction is popped against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (fetch_en && rst) begin
        if (!stall) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_fetch: instr 0x%08h presented with empty scoreboard", instr);
          end else begin
            e = exp_q.pop_front();
            chk("instr", instr, e.data);
          end
        end else begin
          chk("stall_nop", instr, 32'h0);
        end
      end
    end
  end

  task automatic issue(input logic [31:0] a, input bit fl);
    pc       = a;
    flush    = fl;
    fetch_en = 1'b1;
    exp_q.push_back('{addr: a, data: mem_word(a)});
    beats_q.delete();
    req_cycles = 0;
  endtask

  // Called on a negedge; returns on the negedge after the fetch was satisfied.
  task automatic wait_done(input string name, output int stalls);
    bit acc;
    int cyc;
    acc    = 1'b0;
    cyc    = 0;
    stalls = 0;
    while (!acc && cyc < TIMEOUT) begin
      #3;
      acc = !stall;
      if (!acc) stalls++;
      @(negedge clk);
      flush = 1'b0;
      cyc++;
    end
    fetch_en = 1'b0;
    if (!acc) tmo(name);
  endtask

  task automatic fetch(input logic [31:0] a, input bit fl, output int stalls);
    bit was_hit;
    was_hit = mdl_hit(a);
    issue(a, fl);
    if (fl) mdl_flush();
    wait_done("fetch_timeout", stalls);
    if (was_hit) begin
      chk("hit_stalls", 32'(stalls), 32'h0);
    end else begin
      chk("miss_stalls", 32'(stalls), 32'(1 + req_cycles));
      chk("beat_count", 32'(beats_q.size()), LINE_WORDS);
      for (int k = 0; k < beats_q.size() && k < int'(LINE_WORDS); k++) begin
        chk("beat_addr", beats_q[k], line_base(a) + 32'(4 * k));
      end
      mdl_fill(a);
    end
  endtask

  initial begin
    int st;
    int n;
    logic [31:0] a;
    logic [31:0] tag;

    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    int n;
    logic [31:0] a;
    logic [31:0] tag;

    mem_ovr[32'h0] = 32'h11;
    mem_ovr[32'h4] = 32'h22;
    mem_ovr[32'h8] = 32'h33;
    mem_ovr[32'hC] = 32'h44;
    mdl_flush();

    // Reset state.
    repeat (2) @(negedge clk);
    #3;
    chk("rst_mem_req", 32'(mem_req), 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_stall", 32'(stall), 32'h1);
    chk("rst_instr", instr, 32'h0);

    // Cold miss on line 0 with ready every cycle, then a same-cycle hit.
    @(negedge clk);
    rst = 1'b1;
    fetch(32'h0, 1'b0, st);
    chk("t1_latency", 32'(st), 32'(1 + LINE_WORDS));
    fetch(32'h8, 1'b0, st);
    chk("t2_mem_req", 32'(mem_req), 32'h0);

    // Conflict eviction at index 0.
    fetch(32'h100, 1'b0, st);
    fetch(32'h0, 1'b0, st);

    // Beat 2 back-pressured for five cycles.
    hold_addr = 32'h108;
    hold_cnt  = 5;
    issue(32'h104, 1'b0);
    n = 0;
    while (!(mem_req && mem_addr == 32'h108) && n < TIMEOUT) begin
      @(negedge clk);
      n++;
    end
    if (n >= TIMEOUT) tmo("t4_reach_beat2");
    for (int i = 0; i < 5; i++) begin
      #3;
      chk("t4_hold_req", 32'(mem_req), 32'h1);
      chk("t4_hold_addr", mem_addr, 32'h108);
      chk("t4_hold_stall", 32'(stall), 32'h1);
      @(negedge clk);
    end
    wait_done("t4_timeout", st);
    mdl_fill(32'h104);
    fetch(32'h100, 1'b0, st);
    fetch(32'h10C, 1'b0, st);

    // Flush on the beat-1 cycle aborts the refill, which then restarts from beat 0.
    issue(32'h0, 1'b0);
    n = 0;
    while (!(mem_req && mem_addr == 32'h4) && n < TIMEOUT) begin
      @(negedge clk);
      n++;
    end
    if (n >= TIMEOUT) tmo("t5_reach_beat1");
    flush = 1'b1;
    mdl_flush();
    @(negedge clk);
    flush = 1'b0;
    #3;
    chk("t5_req_drop", 32'(mem_req), 32'h0);
    chk("t5_stall", 32'(stall), 32'h1);
    @(negedge clk);
    #3;
    chk("t5_restart_req", 32'(mem_req), 32'h1);
    chk("t5_restart_addr", mem_addr, 32'h0);
    @(negedge clk);
    wait_done("t5_timeout", st);
    mdl_fill(32'h0);
    fetch(32'h104, 1'b0, st);

    // Asynchronous reset in the middle of a refill.
    hold_addr = 32'h310;
    hold_cnt  = 50;
    issue(32'h314, 1'b0);
    n = 0;
    while (!mem_req && n < TIMEOUT) begin
      @(negedge clk);
      n++;
    end
    if (n >= TIMEOUT) tmo("t6_reach_refill");
    #1;
    rst = 1'b0;
    #1;
    chk("t6_mem_req", 32'(mem_req), 32'h0);
    chk("t6_mem_addr", mem_addr, 32'h0);
    chk("t6_stall", 32'(stall), 32'h1);
`ifdef ICACHE_STATS_EN
    chk("t6_hit_cnt", hit_cnt, 32'h0);
    chk("t6_miss_cnt", miss_cnt, 32'h0);
`endif
    hold_cnt = 0;
    mdl_flush();
    @(negedge clk);
    rst = 1'b1;
    wait_done("t6_timeout", st);
    mdl_fill(32'h314);
    fetch(32'h0, 1'b0, st);

    // Randomised stream: mixed tags incl. top of address space, random ready, occasional flush.
    ready_pct = 70;
    for (int i = 0; i < 250; i++) begin
      case ($urandom_range(4))
        0:       tag = 32'h0;
        1:       tag = 32'h1;
        2:       tag = 32'h2;
        3:       tag = 32'h3;
        default: tag = 32'h00FF_FFFF;
      endcase
      a = (tag << 8) | (32'($urandom_range(LINES - 1)) << 4) | (32'($urandom_range(LINE_WORDS - 1)) << 2);
      fetch(a, ($urandom_range(19) == 0), st);
    end

    repeat (3) @(negedge clk);
    chk("pending", 32'(exp_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
